bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Shares the PET's single SRAM/IO bus between three requesters: the video fetcher, the 6502 CPU and the SPI bridge to the MCU. Each requester uses a level request / one-cycle done pulse handshake. The arbiter picks one winner per bus cycle and drives a fixed SETUP → STROBE → HOLD sequence with programmable phase lengths. It sits between the requester front-ends and the bus drivers; its `strobe` output is the qualified RAM/IO access enable.

## Interface
- `SETUP_CYCLES`, default 1: cycles of address/data setup before strobe; legal range 1..15.
- `STROBE_CYCLES`, default 2: cycles `strobe` is high; legal range 1..15.
- `HOLD_CYCLES`, default 1: cycles after strobe before release; legal range 1..15.
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations before SPI is promoted; legal range 1..15.
- `clk`  in  1  single system clock, all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `video_req`  in  1  video request, level, held until `video_done`.
- `cpu_req`  in  1  CPU request, level, held until `cpu_done`.
- `spi_req`  in  1  SPI bridge request, level, held until `spi_done`.
- `grant`  out  3  one-hot owner `{spi,cpu,video}`; 0 when idle.
- `bus_oe`  out  1  bus driven by owner (SETUP through HOLD).
- `strobe`  out  1  access enable, high only in STROBE.
- `video_done`, `cpu_done`, `spi_done`  out  1 each  one-cycle completion pulse to the owner.
- `busy`  out  1  high in any state except IDLE.

## Operation
- Reset values: FSM IDLE, `grant`=0, `bus_oe`=0, `strobe`=0, all `*_done`=0, `busy`=0, phase counter 0, starvation counter 0.
- Reset mid-transaction aborts immediately with no done pulse. The first arbitration happens on the first rising edge after `reset_n` rises.
- FSM states: IDLE → SETUP → STROBE → HOLD → IDLE.
  - A 4-bit phase counter loads N-1 on entry to each timed state and decrements to 0.
  - A state is left on the edge where the counter is 0.
- IDLE: sample the requests on each edge.
  - If any request is high, register the one-hot winner into `grant`, set `bus_oe`, and enter SETUP.
  - If no request is high, stay in IDLE.
- Priority:
  - If `spi_req` is high and the starvation counter equals `STARVE_LIMIT`, SPI wins.
  - Otherwise the order is video > cpu > spi.
- Starvation counter, evaluated at each IDLE grant:
  - +1 (saturating at `STARVE_LIMIT`) when `spi_req` is high and SPI loses.
  - Cleared when SPI is granted.
  - Cleared in IDLE whenever `spi_req` is low.
- `grant` and `bus_oe` are constant for the whole transaction. Requests changing after the grant are ignored until the next IDLE.
- A request dropped before it is granted is a withdrawal: no done pulse, no bus cycle.
- A request dropped after it is granted does not abort: the sequence completes and the owner's done still pulses.
- Done: the owner's `*_done` is high for exactly one cycle, the final HOLD cycle. Other dones stay 0, and at most one done is high at any time.
- Requester obligation: drop `req` on the edge that samples `done`=1. A request still high in the following IDLE cycle is a new request.

## Timing
With defaults, `cpu_req` high alone before edge E0 while IDLE:
- E0: `grant`=010, `bus_oe`=1, `busy`=1, SETUP.
- E1: STROBE, `strobe`=1.
- E3: HOLD, `strobe`=0, `cpu_done`=1.
- E4: IDLE, `grant`=0, `bus_oe`=0, `busy`=0, `cpu_done`=0.
- E5: earliest next grant.

General rules:
- Grant latency from a request sampled in IDLE: 0 cycles (registered on that edge).
- Transaction length: SETUP_CYCLES+STROBE_CYCLES+HOLD_CYCLES cycles of `grant`.
- Minimum period: that length +1, since one IDLE cycle is guaranteed between grants.
- Worst-case SPI wait under continuous video/CPU load: `STARVE_LIMIT`+1 transactions.
- `strobe` is never high while `bus_oe` is low. `grant` never changes while `strobe` is high.

## Test plan
- Single CPU request, defaults → `grant`=010 at E0, `strobe` high E1–E3, `cpu_done` pulse E3–E4, `grant`=0 at E4.
- All three requests high simultaneously, then each dropped on its done → grant order video, cpu, spi; 5-cycle period; exactly one done per transaction.
- `video_req` and `cpu_req` held high continuously, `spi_req` high, `STARVE_LIMIT`=4 → SPI granted on the 5th arbitration; counter returns to 0 afterwards.
- `spi_req` pulsed high then low while video owns the bus → no SPI grant, no `spi_done`, starvation counter 0.
- `reset_n` low during STROBE → `strobe`, `grant`, `bus_oe` and `busy` go to 0 asynchronously; no done pulse; after release, a pending `cpu_req` is granted on the first edge.
- `SETUP_CYCLES`=3, `STROBE_CYCLES`=1, `HOLD_CYCLES`=2, with `cpu_req` re-asserted right after its done → `strobe` high one cycle at offset 3, done at offset 5, next grant at offset 7.

Source files
------------

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - three-way bus arbiter with timed SETUP/STROBE/HOLD access sequence
//
// Purpose: shares one SRAM/IO bus between the video fetcher, the 6502 CPU and
// the SPI bridge. One winner is picked per bus cycle in IDLE. The winner then
// owns the bus for a fixed SETUP -> STROBE -> HOLD sequence whose phase lengths
// are parameters. SPI is promoted over video/CPU after STARVE_LIMIT
// consecutive lost arbitrations.
//
// Ports:
//   clk                  system clock, all state on the rising edge
//   reset_n              asynchronous active-low reset
//   video_req/cpu_req/spi_req
//                        level requests, held until the matching done
//   grant[2:0]           one-hot owner {spi,cpu,video}, 0 when idle
//   bus_oe               bus driven by the owner (SETUP through HOLD)
//   strobe               qualified RAM/IO access enable, high only in STROBE
//   video_done/cpu_done/spi_done
//                        one-cycle completion pulse in the final HOLD cycle
//   busy                 high in any state other than IDLE
module bus_arbiter #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       video_req,
    input  logic       cpu_req,
    input  logic       spi_req,
    output logic [2:0] grant,
    output logic       bus_oe,
    output logic       strobe,
    output logic       video_done,
    output logic       cpu_done,
    output logic       spi_done,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_HOLD
    } state_t;

    // Phase counters load N-1 so a state lasts exactly N cycles.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t     state, state_nxt;
    logic [3:0] phase_cnt, phase_cnt_nxt;
    logic [3:0] starve_cnt, starve_cnt_nxt;
    logic [2:0] grant_nxt;
    logic [2:0] winner;
    logic [2:0] done_vec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            phase_cnt  <= 4'd0;
            starve_cnt <= 4'd0;
            grant      <= 3'b000;
        end else begin
            state      <= state_nxt;
            phase_cnt  <= phase_cnt_nxt;
            starve_cnt <= starve_cnt_nxt;
            grant      <= grant_nxt;
        end
    end

    // Winner selection: a starved SPI request overrides the fixed
    // video > cpu > spi order.
    always_comb begin
        winner = 3'b000;
        if (spi_req && (starve_cnt == STARVE_MAX)) begin
            winner = 3'b100;
        end else if (video_req) begin
            winner = 3'b001;
        end else if (cpu_req) begin
            winner = 3'b010;
        end else if (spi_req) begin
            winner = 3'b100;
        end
    end

    always_comb begin
        state_nxt      = state;
        phase_cnt_nxt  = phase_cnt;
        starve_cnt_nxt = starve_cnt;
        grant_nxt      = grant;
        unique case (state)
            S_IDLE: begin
                grant_nxt = 3'b000;
                if (winner != 3'b000) begin
                    grant_nxt     = winner;
                    state_nxt     = S_SETUP;
                    phase_cnt_nxt = SETUP_LD;
                end
                // Only a pending SPI request that loses keeps aging; any IDLE
                // cycle without an SPI request forgets its history.
                if (!spi_req || winner[2]) begin
                    starve_cnt_nxt = 4'd0;
                end else if (starve_cnt != STARVE_MAX) begin
                    starve_cnt_nxt = starve_cnt + 4'd1;
                end
            end
            S_SETUP: begin
                if (phase_cnt == 4'd0) begin
                    state_nxt     = S_STROBE;
                    phase_cnt_nxt = STROBE_LD;
                end else begin
                    phase_cnt_nxt = phase_cnt - 4'd1;
                end
            end
            S_STROBE: begin
                if (phase_cnt == 4'd0) begin
                    state_nxt     = S_HOLD;
                    phase_cnt_nxt = HOLD_LD;
                end else begin
                    phase_cnt_nxt = phase_cnt - 4'd1;
                end
            end
            S_HOLD: begin
                if (phase_cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                    grant_nxt = 3'b000;
                end else begin
                    phase_cnt_nxt = phase_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt     = S_IDLE;
                phase_cnt_nxt = 4'd0;
                grant_nxt     = 3'b000;
            end
        endcase
    end

    // All outputs decode registered state only, so reset clears them
    // asynchronously and they never glitch on request changes.
    assign busy     = (state != S_IDLE);
    assign bus_oe   = (state != S_IDLE);
    assign strobe   = (state == S_STROBE);
    assign done_vec = ((state == S_HOLD) && (phase_cnt == 4'd0)) ? grant : 3'b000;

    assign video_done = done_vec[0];
    assign cpu_done   = done_vec[1];
    assign spi_done   = done_vec[2];

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a transaction-position model
module tb_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic [1:0][2:0] req;    // per instance {spi,cpu,video}
    logic [1:0][2:0] grant;
    logic [1:0][2:0] dn;
    logic [1:0]      oe;
    logic [1:0]      stb;
    logic [1:0]      bsy;

    bus_arbiter u_def (
        .clk(clk), .reset_n(reset_n),
        .video_req(req[0][0]), .cpu_req(req[0][1]), .spi_req(req[0][2]),
        .grant(grant[0]), .bus_oe(oe[0]), .strobe(stb[0]),
        .video_done(dn[0][0]), .cpu_done(dn[0][1]), .spi_done(dn[0][2]),
        .busy(bsy[0])
    );

    bus_arbiter #(.SETUP_CYCLES(3), .STROBE_CYCLES(1), .HOLD_CYCLES(2), .STARVE_LIMIT(2)) u_alt (
        .clk(clk), .reset_n(reset_n),
        .video_req(req[1][0]), .cpu_req(req[1][1]), .spi_req(req[1][2]),
        .grant(grant[1]), .bus_oe(oe[1]), .strobe(stb[1]),
        .video_done(dn[1][0]), .cpu_done(dn[1][1]), .spi_done(dn[1][2]),
        .busy(bsy[1])
    );

    // Reference model: a transaction is a window of S+T+H cycles counted from
    // the grant edge; strobe covers positions S..S+T-1, done is the last one.
    int p_s[2]   = '{1, 3};
    int p_t[2]   = '{2, 1};
    int p_h[2]   = '{1, 2};
    int p_lim[2] = '{4, 2};
    int m_busy[2], m_pos[2], m_owner[2], m_starve[2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int plen(int i);
        return p_s[i] + p_t[i] + p_h[i];
    endfunction

    function automatic logic [2:0] e_grant(int i);
        return (m_busy[i] != 0) ? 3'(1 << m_owner[i]) : 3'b000;
    endfunction

    function automatic logic e_strobe(int i);
        return (m_busy[i] != 0) && (m_pos[i] >= p_s[i]) && (m_pos[i] < p_s[i] + p_t[i]);
    endfunction

    function automatic logic [2:0] e_done(int i);
        return ((m_busy[i] != 0) && (m_pos[i] == plen(i) - 1)) ? 3'(1 << m_owner[i]) : 3'b000;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 0; m_pos[i] = 0; m_owner[i] = 0; m_starve[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        logic [2:0] r;
        int win;
        r = req[i];
        if (!reset_n) begin
            m_busy[i] = 0; m_pos[i] = 0; m_owner[i] = 0; m_starve[i] = 0;
        end else if (m_busy[i] == 0) begin
            win = -1;
            if (r[2] && m_starve[i] == p_lim[i]) win = 2;
            else if (r[0]) win = 0;
            else if (r[1]) win = 1;
            else if (r[2]) win = 2;
            if (!r[2] || win == 2) m_starve[i] = 0;
            else if (m_starve[i] < p_lim[i]) m_starve[i]++;
            if (win >= 0) begin
                m_busy[i] = 1; m_pos[i] = 0; m_owner[i] = win;
            end
        end else begin
            m_pos[i]++;
            if (m_pos[i] == plen(i)) begin
                m_busy[i] = 0; m_pos[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("grant[%0d]", i),  32'(grant[i]), 32'(e_grant(i)));
            check($sformatf("bus_oe[%0d]", i), 32'(oe[i]),    32'(m_busy[i] != 0));
            check($sformatf("busy[%0d]", i),   32'(bsy[i]),   32'(m_busy[i] != 0));
            check($sformatf("strobe[%0d]", i), 32'(stb[i]),   32'(e_strobe(i)));
            check($sformatf("done[%0d]", i),   32'(dn[i]),    32'(e_done(i)));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all();
    endtask

    // Requester obligation: drop the request once its done is seen.
    task automatic drop_done(input int i);
        logic [2:0] d;
        d = e_done(i);
        for (int k = 0; k < 3; k++) if (d[k]) req[i][k] = 1'b0;
    endtask

    initial begin
        logic [2:0] order [$];
        int gcyc [$];
        int cnt, g0, first_stb, n_stb, done_off, next_off;
        logic saw_spi, rearm;
        logic [2:0] prev;

        // Reset state
        reset_n = 1'b0;
        req = '0;
        model_reset();
        #1;
        check_all();
        repeat (2) cycle();
        @(negedge clk);
        reset_n = 1'b1;

        // Single CPU request, defaults
        req[0] = 3'b010;
        cycle();
        check("e0_grant", 32'(grant[0]), 32'(3'b010));
        for (int k = 1; k <= 4; k++) begin
            cycle();
            if (k == 1) check("e1_strobe", 32'(stb[0]), 32'd1);
            if (k == 3) check("e3_cpu_done", 32'(dn[0][1]), 32'd1);
            if (k == 4) check("e4_grant", 32'(grant[0]), 32'd0);
            drop_done(0);
        end

        // All three at once, each dropped on its done
        req[0] = 3'b111;
        for (int c = 0; c < 20; c++) begin
            prev = grant[0];
            cycle();
            if (prev == 3'b000 && grant[0] != 3'b000) begin
                order.push_back(grant[0]);
                gcyc.push_back(c);
            end
            drop_done(0);
        end
        check("order_cnt", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            check("order0", 32'(order[0]), 32'(3'b001));
            check("order1", 32'(order[1]), 32'(3'b010));
            check("order2", 32'(order[2]), 32'(3'b100));
            check("period01", 32'(gcyc[1] - gcyc[0]), 32'd5);
            check("period12", 32'(gcyc[2] - gcyc[1]), 32'd5);
        end

        // Starvation: video/cpu held, SPI wins the 5th arbitration, twice
        req[0] = 3'b000;
        cycle();
        req[0] = 3'b111;
        for (int round = 0; round < 2; round++) begin
            cnt = 0;
            for (int c = 0; c < 60; c++) begin
                prev = grant[0];
                cycle();
                if (prev == 3'b000 && grant[0] != 3'b000) cnt++;
                if (grant[0] == 3'b100) break;
            end
            check($sformatf("starve_arb_r%0d", round), 32'(cnt), 32'd5);
            req[0][2] = 1'b0;   // dropped after grant: sequence still completes
            repeat (6) cycle();
            req[0][2] = 1'b1;
        end
        req[0] = 3'b000;
        repeat (8) cycle();

        // SPI pulse while video owns the bus is a withdrawal
        req[0] = 3'b001;
        cycle();
        req[0][2] = 1'b1;
        cycle();
        req[0][2] = 1'b0;
        saw_spi = 1'b0;
        for (int c = 0; c < 8; c++) begin
            cycle();
            if (grant[0][2] || dn[0][2]) saw_spi = 1'b1;
            drop_done(0);
        end
        check("spi_withdrawn", 32'(saw_spi), 32'd0);

        // Reset during STROBE
        req[0] = 3'b010;
        for (int c = 0; c < 10; c++) begin
            cycle();
            if (e_strobe(0)) break;
        end
        check("pre_rst_strobe", 32'(stb[0]), 32'd1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        check("rst_async_strobe", 32'(stb[0]), 32'd0);
        repeat (2) cycle();
        @(negedge clk);
        reset_n = 1'b1;
        cycle();
        check("post_rst_grant", 32'(grant[0]), 32'(3'b010));
        for (int c = 0; c < 6; c++) begin
            cycle();
            drop_done(0);
        end

        // Alternate timing instance: 3/1/2 with CPU re-asserted after done
        req[1] = 3'b010;
        g0 = -1; first_stb = -1; n_stb = 0; done_off = -1; next_off = -1;
        rearm = 1'b0;
        for (int c = 0; c < 20; c++) begin
            prev = grant[1];
            cycle();
            if (g0 < 0 && grant[1] != 3'b000) g0 = c;
            if (g0 >= 0) begin
                if (prev == 3'b000 && grant[1] != 3'b000 && c != g0 && next_off < 0) next_off = c - g0;
                if (next_off < 0 && stb[1]) begin
                    n_stb++;
                    if (first_stb < 0) first_stb = c - g0;
                end
                if (done_off < 0 && dn[1] != 3'b000) done_off = c - g0;
            end
            if (rearm) begin
                req[1] = 3'b010;
                rearm = 1'b0;
            end
            if (e_done(1) != 3'b000 && next_off < 0) begin
                req[1] = 3'b000;
                rearm = 1'b1;
            end
        end
        check("alt_strobe_off", 32'(first_stb), 32'd3);
        check("alt_strobe_len", 32'(n_stb), 32'd1);
        check("alt_done_off", 32'(done_off), 32'd5);
        check("alt_next_grant", 32'(next_off), 32'd7);
        req[1] = 3'b000;
        repeat (10) cycle();

        // Randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            cycle();
            for (int i = 0; i < 2; i++) begin
                logic [2:0] d;
                d = e_done(i);
                for (int k = 0; k < 3; k++) begin
                    if (req[i][k]) begin
                        if (d[k] || $urandom_range(15) == 0) req[i][k] = 1'b0;
                    end else if ($urandom_range(3) == 0) begin
                        req[i][k] = 1'b1;
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
